axi4_burst_mem_slave: RTL and testbench

AXI4 (full) memory-mapped slave with internal word-addressed storage, responding to master-side INCR/FIXED bursts such as the 8-beat, 32-bit write/read bursts our IP example benches issue on S00_AXI. Independent write and read engines give one beat per cycle. It is the responder-side model and scratch-memory endpoint for framegrabber subsystem simulation and integration.

---
 rtl/axi4_slv_pkg.sv | 21 ++
 rtl/axi4_slv_addr_gen.sv | 49 ++++
 rtl/axi4_burst_mem_slave.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slv_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4 burst memory slave.
// The AXI_SLV_WRAP_EN macro (see axi4_slv_addr_gen / axi4_burst_mem_slave) enables WRAP bursts.
package axi4_slv_pkg;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // WRAP lengths whose beat count is a power of two between 2 and 16.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_slv_addr_gen.sv
// Combinational next-word-index generator for FIXED/INCR bursts.
// WRAP support is compiled in only when AXI_SLV_WRAP_EN is defined.
module axi4_slv_addr_gen
    import axi4_slv_pkg::*;
#(
    parameter int unsigned IdxWidth = 4
) (
    input  logic [IdxWidth-1:0] addr_i,
    input  logic [7:0]          len_i,
    input  logic [1:0]          burst_i,
    output logic [IdxWidth-1:0] next_o
);

    logic [IdxWidth-1:0] incr;
    assign incr = addr_i + IdxWidth'(1);

`ifdef AXI_SLV_WRAP_EN
    localparam int unsigned LenExtW = (IdxWidth > 8) ? IdxWidth : 8;
    logic [LenExtW-1:0]  len_ext;
    logic [IdxWidth-1:0] wrap_mask;
    logic                unused_len;

    // For legal wrap lengths, len is exactly the mask of the wrapping low index bits.
    assign len_ext    = LenExtW'(len_i);
    assign wrap_mask  = len_ext[IdxWidth-1:0];
    assign unused_len = ^len_ext;

    always_comb begin
        next_o = incr;
        case (burst_i)
            BurstFixed: next_o = addr_i;
            BurstWrap:  next_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
            default:    next_o = incr;
        endcase
    end
`else
    logic unused_len;
    assign unused_len = ^len_i;

    always_comb begin
        next_o = incr;
        case (burst_i)
            BurstFixed: next_o = addr_i;
            default:    next_o = incr;
        endcase
    end
`endif

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 slave with word-addressed scratch memory and independent write/read burst engines.
// Define AXI_SLV_WRAP_EN to accept WRAP bursts; otherwise WRAP answers SLVERR.
module axi4_burst_mem_slave
    import axi4_slv_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic [3:0]                      S_AXI_AWREGION,
    input  logic [0:0]                      S_AXI_AWUSER,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic [0:0]                      S_AXI_WUSER,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic [0:0]                      S_AXI_BUSER,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [3:0]                      S_AXI_ARREGION,
    input  logic [0:0]                      S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic [0:0]                      S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned IW      = C_S_AXI_ID_WIDTH;
    localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
    localparam int unsigned StrbW   = DW / 8;
    localparam int unsigned SizeLog = $clog2(StrbW);
    localparam int unsigned IdxW    = C_S_AXI_ADDR_WIDTH - SizeLog;
    localparam int unsigned Words   = 2 ** IdxW;
    localparam logic [2:0]  ExpSize = 3'(SizeLog);

    logic [DW-1:0] mem_q [Words];

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                             S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WUSER, S_AXI_ARLOCK,
                             S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
                             S_AXI_ARUSER, S_AXI_AWADDR[SizeLog-1:0],
                             S_AXI_ARADDR[SizeLog-1:0]};
    assign S_AXI_BUSER = 1'b0;
    assign S_AXI_RUSER = 1'b0;

    // Request legality, evaluated on the address handshake.
    logic aw_wrap_err, ar_wrap_err, aw_err, ar_err;
`ifdef AXI_SLV_WRAP_EN
    assign aw_wrap_err = (S_AXI_AWBURST == BurstWrap) && !wrap_len_ok(S_AXI_AWLEN);
    assign ar_wrap_err = (S_AXI_ARBURST == BurstWrap) && !wrap_len_ok(S_AXI_ARLEN);
`else
    assign aw_wrap_err = (S_AXI_AWBURST == BurstWrap);
    assign ar_wrap_err = (S_AXI_ARBURST == BurstWrap);
`endif
    assign aw_err = (S_AXI_AWSIZE != ExpSize) || (S_AXI_AWBURST == BurstRsvd) || aw_wrap_err;
    assign ar_err = (S_AXI_ARSIZE != ExpSize) || (S_AXI_ARBURST == BurstRsvd) || ar_wrap_err;

    // ---------------- write engine ----------------
    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [IW-1:0]     bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [IdxW-1:0]   w_idx_q, w_idx_d, w_idx_next;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic              w_err_q, w_err_d, w_last_err_q, w_last_err_d;
    logic              aw_hs, w_hs, b_hs, w_final;

    assign aw_hs   = awready_q && S_AXI_AWVALID;
    assign w_hs    = wready_q && S_AXI_WVALID;
    assign b_hs    = bvalid_q && S_AXI_BREADY;
    assign w_final = (w_cnt_q == w_len_q);

    axi4_slv_addr_gen #(.IdxWidth(IdxW)) u_w_addr_gen (
        .addr_i  (w_idx_q),
        .len_i   (w_len_q),
        .burst_i (w_burst_q),
        .next_o  (w_idx_next)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) w_state_q <= WIdle;
        else          w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle:   if (aw_hs) w_state_d = WData;
            WData:   if (w_hs && w_final) w_state_d = WResp;
            WResp:   if (b_hs) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        awready_d = (w_state_d == WIdle);
        wready_d  = (w_state_d == WData);
        bvalid_d  = (w_state_d == WResp);
    end

    always_comb begin
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        w_idx_d      = w_idx_q;
        w_len_d      = w_len_q;
        w_burst_d    = w_burst_q;
        w_cnt_d      = w_cnt_q;
        w_err_d      = w_err_q;
        w_last_err_d = w_last_err_q;
        if (aw_hs) begin
            bid_d        = S_AXI_AWID;
            w_idx_d      = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:SizeLog];
            w_len_d      = S_AXI_AWLEN;
            w_burst_d    = S_AXI_AWBURST;
            w_cnt_d      = 8'd0;
            w_err_d      = aw_err;
            w_last_err_d = 1'b0;
        end else if (w_hs) begin
            w_idx_d = w_idx_next;
            w_cnt_d = w_cnt_q + 8'd1;
            if (S_AXI_WLAST != w_final) w_last_err_d = 1'b1;
            if (w_final) bresp_d = (w_err_q || w_last_err_d) ? RespSlverr : RespOkay;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= RespOkay;
            w_idx_q      <= '0;
            w_len_q      <= 8'd0;
            w_burst_q    <= BurstFixed;
            w_cnt_q      <= 8'd0;
            w_err_q      <= 1'b0;
            w_last_err_q <= 1'b0;
        end else begin
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bid_q        <= bid_d;
            bresp_q      <= bresp_d;
            w_idx_q      <= w_idx_d;
            w_len_q      <= w_len_d;
            w_burst_q    <= w_burst_d;
            w_cnt_q      <= w_cnt_d;
            w_err_q      <= w_err_d;
            w_last_err_q <= w_last_err_d;
        end
    end

    // Contents survive reset; a beat coinciding with reset assertion is dropped.
    always_ff @(posedge ACLK) begin
        if (ARESETN && w_hs && !w_err_q) begin
            for (int b = 0; b < StrbW; b++) begin
                if (S_AXI_WSTRB[b]) mem_q[w_idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;

    // ---------------- read engine ----------------
    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [IW-1:0]     rid_q, rid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [IdxW-1:0]   r_idx_q, r_idx_d, r_idx_next, ar_idx;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic              r_err_q, r_err_d, ar_hs, r_hs;

    assign ar_hs  = arready_q && S_AXI_ARVALID;
    assign r_hs   = rvalid_q && S_AXI_RREADY;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:SizeLog];

    axi4_slv_addr_gen #(.IdxWidth(IdxW)) u_r_addr_gen (
        .addr_i  (r_idx_q),
        .len_i   (r_len_q),
        .burst_i (r_burst_q),
        .next_o  (r_idx_next)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_state_q <= RIdle;
        else          r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:   if (ar_hs) r_state_d = RData;
            RData:   if (r_hs && rlast_q) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        arready_d = (r_state_d == RIdle);
        rvalid_d  = (r_state_d == RData);
    end

    // RDATA is prefetched from the array at the handshake edge, so it sees pre-write contents.
    always_comb begin
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        if (ar_hs) begin
            rid_d     = S_AXI_ARID;
            r_idx_d   = ar_idx;
            r_len_d   = S_AXI_ARLEN;
            r_burst_d = S_AXI_ARBURST;
            r_cnt_d   = 8'd0;
            r_err_d   = ar_err;
            rdata_d   = ar_err ? '0 : mem_q[ar_idx];
            rresp_d   = ar_err ? RespSlverr : RespOkay;
            rlast_d   = (S_AXI_ARLEN == 8'd0);
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_d = 1'b0;
            end else begin
                r_idx_d = r_idx_next;
                r_cnt_d = r_cnt_q + 8'd1;
                rdata_d = r_err_q ? '0 : mem_q[r_idx_next];
                rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_burst_q <= BurstFixed;
            r_cnt_q   <= 8'd0;
            r_err_q   <= 1'b0;
        end else begin
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave; WRAP expectations follow AXI_SLV_WRAP_EN.
module tb_axi4_burst_mem_slave;

    localparam int Timeout = 64;

    logic        clk, aresetn;
    logic [0:0]  awid, bid, arid, rid;
    logic [5:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [0:0]  buser, ruser;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [16];
    logic [31:0] exp_data_q [$];
    logic        exp_last_q [$];
    logic [2:0]  exp_b_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    axi4_burst_mem_slave dut (
        .ACLK           (clk),
        .ARESETN        (aresetn),
        .S_AXI_AWID     (awid),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWLEN    (awlen),
        .S_AXI_AWSIZE   (awsize),
        .S_AXI_AWBURST  (awburst),
        .S_AXI_AWLOCK   (1'b0),
        .S_AXI_AWCACHE  (4'd0),
        .S_AXI_AWPROT   (3'd0),
        .S_AXI_AWQOS    (4'd0),
        .S_AXI_AWREGION (4'd0),
        .S_AXI_AWUSER   (1'b0),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WLAST    (wlast),
        .S_AXI_WUSER    (1'b0),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BID      (bid),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BUSER    (buser),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARID     (arid),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARLEN    (arlen),
        .S_AXI_ARSIZE   (arsize),
        .S_AXI_ARBURST  (arburst),
        .S_AXI_ARLOCK   (1'b0),
        .S_AXI_ARCACHE  (4'd0),
        .S_AXI_ARPROT   (3'd0),
        .S_AXI_ARQOS    (4'd0),
        .S_AXI_ARREGION (4'd0),
        .S_AXI_ARUSER   (1'b0),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RID      (rid),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RLAST    (rlast),
        .S_AXI_RUSER    (ruser),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        logic e;
        e = (size != 3'd2) || (burst == 2'b11);
`ifdef AXI_SLV_WRAP_EN
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
`else
        if (burst == 2'b10 && len != 8'hFF) e = 1'b1;
        if (burst == 2'b10) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic [7:0] len,
                                            input logic [1:0] burst);
        logic [3:0] m;
        m = len[3:0];
        if (burst == 2'b00) return idx;
`ifdef AXI_SLV_WRAP_EN
        if (burst == 2'b10) return (idx & ~m) | ((idx + 4'd1) & m);
`endif
        return idx + 4'd1;
    endfunction

    task automatic do_write(input logic [0:0] id, input logic [5:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] strb, input bit bad_last, input logic [31:0] base);
        logic       err, hs;
        logic [3:0] idx;
        logic [31:0] d;
        int         stalls;
        logic [2:0] exp_b;
        err = req_err(size, burst, len);
        exp_b_q.delete();
        exp_b_q.push_back({id, (err || bad_last) ? 2'b10 : 2'b00});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < Timeout && !hs; n++) begin
            hs = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        chk("aw_handshake", 32'(hs), 32'd1);
        chk("wready_after_aw", 32'(wready), 32'd1);
        idx = addr[5:2];
        stalls = 0;
        for (int i = 0; i <= int'(len); i++) begin
            d = base + 32'(i);
            wvalid = 1'b1; wdata = d; wstrb = strb;
            wlast = bad_last ? (i == 0) : (i == int'(len));
            hs = 1'b0;
            for (int n = 0; n < Timeout && !hs; n++) begin
                hs = wready;
                if (!hs) stalls++;
                @(posedge clk); #1;
            end
            if (!err) begin
                for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
            idx = next_idx(idx, len, burst);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("w_stalls", 32'(stalls), 32'd0);
        chk("bvalid_latency", 32'(bvalid), 32'd1);
        exp_b = exp_b_q.pop_front();
        chk("bid", 32'(bid), 32'(exp_b[2]));
        chk("bresp", 32'(bresp), 32'(exp_b[1:0]));
        @(posedge clk); #1;
        chk("bvalid_held", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_cleared", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [0:0] id, input logic [5:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        logic        err, hs, stall_prev, last_prev;
        logic [3:0]  idx;
        logic [31:0] data_prev, ed;
        logic        el;
        logic [1:0]  eresp;
        int          beats, cyc;
        err = req_err(size, burst, len);
        eresp = err ? 2'b10 : 2'b00;
        exp_data_q.delete(); exp_last_q.delete();
        idx = addr[5:2];
        for (int i = 0; i <= int'(len); i++) begin
            exp_data_q.push_back(err ? 32'h0 : model[idx]);
            exp_last_q.push_back(i == int'(len));
            idx = next_idx(idx, len, burst);
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < Timeout && !hs; n++) begin
            hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        chk("ar_handshake", 32'(hs), 32'd1);
        chk("rvalid_latency", 32'(rvalid), 32'd1);
        beats = 0; cyc = 0; stall_prev = 1'b0; data_prev = '0; last_prev = 1'b0;
        while (beats <= int'(len) && cyc < 4 * Timeout) begin
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stall_prev) begin
                chk("rdata_stable", rdata, data_prev);
                chk("rlast_stable", 32'(rlast), 32'(last_prev));
            end
            if (rvalid && rready) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                chk("rdata", rdata, ed);
                chk("rlast", 32'(rlast), 32'(el));
                chk("rresp", 32'(rresp), 32'(eresp));
                chk("rid", 32'(rid), 32'(id));
                beats++;
            end
            stall_prev = rvalid && !rready;
            data_prev = rdata; last_prev = rlast;
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        chk("r_beats", 32'(beats), 32'(int'(len) + 1));
        chk("rvalid_after_last", 32'(rvalid), 32'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        chk("awready_after_rst", 32'(awready), 32'd1);
        chk("arready_after_rst", 32'(arready), 32'd1);

        // Give every word a known value first.
        do_write(1'b0, 6'h00, 8'd15, 3'd2, 2'b01, 4'hF, 1'b0, 32'hA000_0000);
        do_read(1'b0, 6'h00, 8'd15, 3'd2, 2'b01, 1'b0);

        do_write(1'b1, 6'h00, 8'd7, 3'd2, 2'b01, 4'hF, 1'b0, 32'd1);
        do_read(1'b1, 6'h00, 8'd7, 3'd2, 2'b01, 1'b0);

        do_write(1'b0, 6'h10, 8'd0, 3'd2, 2'b01, 4'hF, 1'b0, 32'h1111_1111);
        do_write(1'b0, 6'h10, 8'd0, 3'd2, 2'b01, 4'b0011, 1'b0, 32'hAABB_CCDD);
        do_read(1'b0, 6'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("strb_model", model[4], 32'h1111_CCDD);

        do_write(1'b1, 6'h08, 8'd3, 3'd2, 2'b00, 4'hF, 1'b0, 32'hA);
        do_read(1'b0, 6'h08, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("fixed_model", model[2], 32'hD);

        do_read(1'b1, 6'h00, 8'd7, 3'd2, 2'b01, 1'b1);

        do_write(1'b1, 6'h20, 8'd0, 3'd1, 2'b01, 4'hF, 1'b0, 32'hDEAD_BEEF);
        do_read(1'b0, 6'h20, 8'd0, 3'd2, 2'b01, 1'b0);
        do_read(1'b1, 6'h20, 8'd3, 3'd1, 2'b01, 1'b0);

        do_write(1'b0, 6'h38, 8'd3, 3'd2, 2'b10, 4'hF, 1'b0, 32'hC0DE_0000);
        do_read(1'b0, 6'h30, 8'd3, 3'd2, 2'b01, 1'b0);
        do_read(1'b1, 6'h38, 8'd3, 3'd2, 2'b10, 1'b0);

        do_write(1'b1, 6'h38, 8'd3, 3'd2, 2'b01, 4'hF, 1'b0, 32'h5A5A_0000);
        do_read(1'b1, 6'h38, 8'd3, 3'd2, 2'b01, 1'b1);

        do_write(1'b0, 6'h28, 8'd1, 3'd2, 2'b01, 4'hF, 1'b1, 32'h55);
        do_read(1'b0, 6'h28, 8'd1, 3'd2, 2'b01, 1'b0);

        do_read(1'b0, 6'h06, 8'd0, 3'd2, 2'b01, 1'b0);
        do_read(1'b0, 6'h00, 8'd0, 3'd2, 2'b11, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
